// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the control unit (master) and alu_mc (slave).
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             busy;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, Zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: valid/ready handshake, shift-add multiply, restoring divide.
// Define ALU_MC_EARLY_OUT_EN to stop mul/mulhu after the most-significant set bit of SrcB.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    reset_n,
  alu_mc_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR   = 4'b0100, OP_SLT  = 4'b0101, OP_SLTU = 4'b0110, OP_SLL  = 4'b0111,
    OP_SRL   = 4'b1000, OP_SRA  = 4'b1001, OP_MUL  = 4'b1010, OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100, OP_REMU = 4'b1101, OP_RSV0 = 4'b1110, OP_RSV1 = 4'b1111
  } alu_op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_hi_q, sel_hi_d;
`ifdef ALU_MC_EARLY_OUT_EN
  logic [CNT_W-1:0] sh_q, sh_d;
`endif

  alu_op_e            op;
  logic [SHAMT_W-1:0] shamt;
  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic [WIDTH-1:0]   alu_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic [WIDTH-1:0]   div_res;

  assign op       = alu_op_e'(bus.ALUControl);
  assign shamt    = bus.SrcB[SHAMT_W-1:0];
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
  // Divide by zero is answered on the single-cycle path.
  assign is_div   = ((op == OP_DIVU) || (op == OP_REMU)) && (bus.SrcB != '0);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
      OP_AND:  alu_res = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res = bus.SrcA | bus.SrcB;
      OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      OP_SLT:  alu_res = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      OP_SLTU: alu_res = WIDTH'(bus.SrcA < bus.SrcB);
      OP_SLL:  alu_res = bus.SrcA << shamt;
      OP_SRL:  alu_res = bus.SrcA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = bus.SrcA;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: hi accumulates, lo shifts out multiplier bits and collects product bits.
  assign mul_sum = {1'b0, hi_q} + ({1'b0, b_q} & {(WIDTH + 1){lo_q[0]}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_EARLY_OUT_EN
  assign mul_full = {mul_hi, mul_lo} >> sh_q;
`else
  assign mul_full = {mul_hi, mul_lo};
`endif
  assign mul_res = sel_hi_q ? mul_full[2*WIDTH-1:WIDTH] : mul_full[WIDTH-1:0];

  // One restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_hi    = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
  assign div_lo    = {lo_q[WIDTH-2:0], div_ge};
  assign div_res   = sel_hi_q ? div_hi : div_lo;

`ifdef ALU_MC_EARLY_OUT_EN
  function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = CNT_W'(i);
    end
    return idx;
  endfunction
`endif

  // NOTE: every signal gets its default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    sel_hi_d    = sel_hi_q;
`ifdef ALU_MC_EARLY_OUT_EN
    sh_d        = sh_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = S_MUL;
            hi_d     = '0;
            lo_d     = bus.SrcB;
            b_d      = bus.SrcA;
            sel_hi_d = (op == OP_MULHU);
`ifdef ALU_MC_EARLY_OUT_EN
            cnt_d    = msb_index(bus.SrcB);
            // WIDTH is a power of two, so WIDTH-1-msb is the bitwise inverse.
            sh_d     = ~msb_index(bus.SrcB);
`else
            cnt_d    = CNT_W'(WIDTH - 1);
`endif
          end else if (is_div) begin
            state_d  = S_DIV;
            hi_d     = '0;
            lo_d     = bus.SrcA;
            b_d      = bus.SrcB;
            sel_hi_d = (op == OP_REMU);
            cnt_d    = CNT_W'(WIDTH - 1);
          end else begin
            res_d       = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          res_d       = mul_res;
          zero_d      = (mul_res == '0);
          out_valid_d = 1'b1;
        end
      end

      S_DIV: begin
        hi_d  = div_hi;
        lo_d  = div_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          res_d       = div_res;
          zero_d      = (div_res == '0);
          out_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: iteration registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    hi_q     <= hi_d;
    lo_q     <= lo_d;
    b_q      <= b_d;
    sel_hi_q <= sel_hi_d;
`ifdef ALU_MC_EARLY_OUT_EN
    sh_q     <= sh_d;
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule
